// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one downstream read channel between icache and dcache
// and buffers a single dcache write, blocking same-line reads while the write is in flight.
module cache_axi_arbiter #(
    parameter int LINE_OFF_BITS = 4,
    parameter bit RR_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_last,
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_last,
    output logic [31:0]  ret_data_o,
    input  logic         d_wr_req,
    input  logic [2:0]   d_wr_type,
    input  logic [31:0]  d_wr_addr,
    input  logic [3:0]   d_wr_wstrb,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,
    output logic         rd_req,
    output logic [2:0]   rd_type,
    output logic [31:0]  rd_addr,
    input  logic         rd_rdy,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data,
    output logic         wr_req,
    output logic [2:0]   wr_type,
    output logic [31:0]  wr_addr,
    output logic [3:0]   wr_wstrb,
    output logic [127:0] wr_data,
    input  logic         wr_rdy,
    input  logic         wr_done
);
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RETURN} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_WAIT} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    logic owner, last_grant;  // 1 = dcache, 0 = icache
    logic [2:0]   wbuf_type;
    logic [31:0]  wbuf_addr;
    logic [3:0]   wbuf_wstrb;
    logic [127:0] wbuf_data;
    logic i_hit, d_hit, i_cand, d_cand, grant, grant_d, own_req, issue, in_ret;

    assign i_hit   = (w_state != W_IDLE) && (i_rd_addr[31:LINE_OFF_BITS] == wbuf_addr[31:LINE_OFF_BITS]);
    assign d_hit   = (w_state != W_IDLE) && (d_rd_addr[31:LINE_OFF_BITS] == wbuf_addr[31:LINE_OFF_BITS]);
    assign i_cand  = i_rd_req && !i_hit;
    assign d_cand  = d_rd_req && !d_hit;
    assign grant   = i_cand || d_cand;
    assign grant_d = d_cand && (!i_cand || !RR_EN || !last_grant);
    assign own_req = owner ? d_rd_req : i_rd_req;
    assign issue   = r_state == R_ISSUE;
    assign in_ret  = r_state == R_RETURN;

    assign rd_req      = issue && own_req;
    assign rd_type     = rd_req ? (owner ? d_rd_type : i_rd_type) : 3'b0;
    assign rd_addr     = rd_req ? (owner ? d_rd_addr : i_rd_addr) : 32'b0;
    assign i_rd_rdy    = rd_req && !owner && rd_rdy;
    assign d_rd_rdy    = rd_req && owner && rd_rdy;
    assign i_ret_valid = in_ret && !owner && ret_valid;
    assign i_ret_last  = i_ret_valid && ret_last;
    assign d_ret_valid = in_ret && owner && ret_valid;
    assign d_ret_last  = d_ret_valid && ret_last;
    assign ret_data_o  = ret_data;

    assign d_wr_rdy = w_state == W_IDLE;
    assign wr_req   = w_state == W_SEND;
    assign wr_type  = wbuf_type;
    assign wr_addr  = wbuf_addr;
    assign wr_wstrb = wbuf_wstrb;
    assign wr_data  = wbuf_data;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:   r_next = grant ? R_ISSUE : R_IDLE;
            R_ISSUE:  r_next = !own_req ? R_IDLE : (rd_rdy ? R_RETURN : R_ISSUE);
            R_RETURN: r_next = (ret_valid && ret_last) ? R_IDLE : R_RETURN;
            default:  r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  w_next = d_wr_req ? W_SEND : W_IDLE;
            W_SEND:  w_next = wr_rdy ? (wr_done ? W_IDLE : W_WAIT) : W_SEND;
            W_WAIT:  w_next = wr_done ? W_IDLE : W_WAIT;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= R_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && grant) begin
                owner      <= grant_d;
                last_grant <= grant_d;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state    <= W_IDLE;
            wbuf_type  <= '0;
            wbuf_addr  <= '0;
            wbuf_wstrb <= '0;
            wbuf_data  <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && d_wr_req) begin
                wbuf_type  <= d_wr_type;
                wbuf_addr  <= d_wr_addr;
                wbuf_wstrb <= d_wr_wstrb;
                wbuf_data  <= d_wr_data;
            end
        end
    end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed checks of read arbitration, RAW blocking, write buffering and async reset.
module tb_cache_axi_arbiter;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         i_rd_req = 0, d_rd_req = 0, d_wr_req = 0;
    logic [2:0]   i_rd_type = 0, d_rd_type = 0, d_wr_type = 0;
    logic [31:0]  i_rd_addr = 0, d_rd_addr = 0, d_wr_addr = 0;
    logic [3:0]   d_wr_wstrb = 0;
    logic [127:0] d_wr_data = 0;
    logic         rd_rdy = 0, ret_valid = 0, ret_last = 0, wr_rdy = 0, wr_done = 0;
    logic [31:0]  ret_data = 0;
    logic         i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
    logic         rd_req, wr_req;
    logic [31:0]  ret_data_o, rd_addr, wr_addr;
    logic [2:0]   rd_type, wr_type;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         z_i_rd_rdy, z_i_ret_valid, z_i_ret_last, z_d_rd_rdy, z_d_ret_valid, z_d_ret_last, z_d_wr_rdy;
    logic         z_rd_req, z_wr_req;
    logic [31:0]  z_ret_data_o, z_rd_addr, z_wr_addr;
    logic [2:0]   z_rd_type, z_wr_type;
    logic [3:0]   z_wr_wstrb;
    logic [127:0] z_wr_data;
    int errors = 0, checks = 0;
    localparam logic [127:0] WDATA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    always #5 clk = ~clk;

    cache_axi_arbiter #(.LINE_OFF_BITS(4), .RR_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .ret_data_o(ret_data_o),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
        .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    cache_axi_arbiter #(.LINE_OFF_BITS(4), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(z_i_rd_rdy),
        .i_ret_valid(z_i_ret_valid), .i_ret_last(z_i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(z_d_rd_rdy),
        .d_ret_valid(z_d_ret_valid), .d_ret_last(z_d_ret_last), .ret_data_o(z_ret_data_o),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
        .d_wr_data(d_wr_data), .d_wr_rdy(z_d_wr_rdy),
        .rd_req(z_rd_req), .rd_type(z_rd_type), .rd_addr(z_rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(z_wr_req), .wr_type(z_wr_type), .wr_addr(z_wr_addr), .wr_wstrb(z_wr_wstrb), .wr_data(z_wr_data),
        .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_d_wr_rdy", d_wr_rdy, 1);
        chk("rst_i_rd_rdy", i_rd_rdy, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        tick;
        resetn = 1;
        // simultaneous requests: RR grants icache then dcache, fixed priority grants dcache twice
        tick;
        i_rd_req = 1; i_rd_addr = 32'h100; i_rd_type = 3'b100;
        d_rd_req = 1; d_rd_addr = 32'h200; d_rd_type = 3'b100;
        @(negedge clk);
        chk("rr_grant_cycle_rd_req", rd_req, 0);
        tick;
        rd_rdy = 1;
        @(negedge clk);
        chk("rr1_rd_addr", rd_addr, 32'h100);
        chk("rr1_i_rd_rdy", i_rd_rdy, 1);
        chk("fixed1_rd_addr", z_rd_addr, 32'h200);
        chk("fixed1_d_rd_rdy", z_d_rd_rdy, 1);
        tick;
        rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'h5;
        @(negedge clk);
        chk("rr1_i_ret_valid", i_ret_valid, 1);
        chk("rr1_d_ret_valid", d_ret_valid, 0);
        chk("rr1_ret_data", ret_data_o, 32'h5);
        tick;
        ret_valid = 0; ret_last = 0;
        tick;
        rd_rdy = 1;
        @(negedge clk);
        chk("rr2_rd_addr", rd_addr, 32'h200);
        chk("rr2_d_rd_rdy", d_rd_rdy, 1);
        chk("fixed2_rd_addr", z_rd_addr, 32'h200);
        tick;
        rd_rdy = 0; ret_valid = 1; ret_last = 1;
        @(negedge clk);
        chk("rr2_d_ret_valid", d_ret_valid, 1);
        tick;
        ret_valid = 0; ret_last = 0; i_rd_req = 0; d_rd_req = 0;
        resetn = 0;
        #2 resetn = 1;
        // single icache refill
        tick;
        i_rd_req = 1; i_rd_addr = 32'h1C00_0100; i_rd_type = 3'b100;
        @(negedge clk);
        chk("single_grant_rd_req", rd_req, 0);
        tick;
        @(negedge clk);
        chk("single_rd_req", rd_req, 1);
        chk("single_rd_addr", rd_addr, 32'h1C00_0100);
        chk("single_rd_type", rd_type, 3'b100);
        chk("single_rdy_early", i_rd_rdy, 0);
        tick;
        rd_rdy = 1;
        @(negedge clk);
        chk("single_i_rd_rdy", i_rd_rdy, 1);
        chk("single_d_rd_rdy", d_rd_rdy, 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            i_rd_req = 0; rd_rdy = 0; ret_valid = 1; ret_last = (k == 3); ret_data = 32'hA + k;
            @(negedge clk);
            chk("single_i_ret_valid", i_ret_valid, 1);
            chk("single_i_ret_last", i_ret_last, (k == 3));
            chk("single_d_ret_valid", d_ret_valid, 0);
            chk("single_ret_data", ret_data_o, 32'hA + k);
        end
        tick;
        ret_last = 0;
        @(negedge clk);
        chk("stray_ret_idle", i_ret_valid, 0);
        // write to line 0x2000 blocks icache read of 0x2008; dcache read of 0x3000 goes ahead
        tick;
        ret_valid = 0;
        d_wr_req = 1; d_wr_addr = 32'h2000; d_wr_data = WDATA; d_wr_wstrb = 4'hF; d_wr_type = 3'b100;
        @(negedge clk);
        chk("wr_idle_rdy", d_wr_rdy, 1);
        chk("wr_idle_req", wr_req, 0);
        tick;
        d_wr_req = 0;
        i_rd_req = 1; i_rd_addr = 32'h2008; d_rd_req = 1; d_rd_addr = 32'h3000;
        @(negedge clk);
        chk("wr_busy_rdy", d_wr_rdy, 0);
        chk("wr_req_send", wr_req, 1);
        chk("wr_data", wr_data, WDATA);
        chk("wr_addr", wr_addr, 32'h2000);
        chk("wr_wstrb", wr_wstrb, 4'hF);
        tick;
        rd_rdy = 1; wr_rdy = 1;
        @(negedge clk);
        chk("raw_other_line_rd_addr", rd_addr, 32'h3000);
        chk("raw_other_line_d_rdy", d_rd_rdy, 1);
        chk("wr_req_held", wr_req, 1);
        tick;
        d_rd_req = 0; rd_rdy = 0; wr_rdy = 0; ret_valid = 1; ret_last = 1;
        @(negedge clk);
        chk("raw_d_ret_valid", d_ret_valid, 1);
        chk("wr_wait_req", wr_req, 0);
        chk("wr_wait_rdy", d_wr_rdy, 0);
        tick;
        ret_valid = 0; ret_last = 0;
        @(negedge clk);
        chk("raw_blocked_1", rd_req, 0);
        tick;
        wr_done = 1;
        @(negedge clk);
        chk("raw_blocked_done", rd_req, 0);
        tick;
        wr_done = 0;
        @(negedge clk);
        chk("wr_back_idle", d_wr_rdy, 1);
        chk("raw_grant_cycle", rd_req, 0);
        tick;
        rd_rdy = 1;
        @(negedge clk);
        chk("raw_released_req", rd_req, 1);
        chk("raw_released_addr", rd_addr, 32'h2008);
        tick;
        i_rd_req = 0; rd_rdy = 0; ret_valid = 1; ret_last = 1;
        @(negedge clk);
        chk("raw_i_ret_valid", i_ret_valid, 1);
        // wr_rdy and wr_done together; a second d_wr_req while busy is dropped
        tick;
        ret_valid = 0; ret_last = 0;
        d_wr_req = 1; d_wr_addr = 32'h4000; d_wr_data = 128'h1234;
        tick;
        d_wr_data = 128'hDEAD; d_wr_addr = 32'h5000; wr_rdy = 1; wr_done = 1;
        @(negedge clk);
        chk("same_cycle_wr_req", wr_req, 1);
        chk("busy_wr_req_ignored", wr_data, 128'h1234);
        tick;
        d_wr_req = 0; wr_rdy = 0; wr_done = 0;
        @(negedge clk);
        chk("same_cycle_idle", d_wr_rdy, 1);
        chk("same_cycle_no_req", wr_req, 0);
        // cancelled icache fetch, pending dcache read granted next
        tick;
        i_rd_req = 1; i_rd_addr = 32'h500;
        d_wr_req = 1; d_wr_addr = 32'h8000;
        tick;
        d_wr_req = 0;
        i_rd_req = 0; d_rd_req = 1; d_rd_addr = 32'h600; rd_rdy = 1;
        @(negedge clk);
        chk("cancel_rd_req", rd_req, 0);
        chk("cancel_i_rd_rdy", i_rd_rdy, 0);
        chk("cancel_d_rd_rdy", d_rd_rdy, 0);
        tick;
        rd_rdy = 0; ret_valid = 1;
        @(negedge clk);
        chk("cancel_no_beat", i_ret_valid, 0);
        chk("cancel_regrant_cycle", rd_req, 0);
        tick;
        ret_valid = 0; rd_rdy = 1;
        @(negedge clk);
        chk("cancel_d_rd_addr", rd_addr, 32'h600);
        chk("cancel_d_rd_rdy2", d_rd_rdy, 1);
        for (int k = 0; k < 2; k++) begin
            tick;
            d_rd_req = 0; rd_rdy = 0; ret_valid = 1; ret_last = 0; ret_data = k + 1;
            @(negedge clk);
            chk("refill_d_ret_valid", d_ret_valid, 1);
        end
        chk("pre_reset_wr_busy", d_wr_rdy, 0);
        // async reset mid-refill, no clock edge before checking
        #2;
        resetn = 0; ret_valid = 0; ret_data = 0;
        #1;
        chk("areset_d_ret_valid", d_ret_valid, 0);
        chk("areset_rd_req", rd_req, 0);
        chk("areset_wr_req", wr_req, 0);
        chk("areset_wr_addr", wr_addr, 0);
        chk("areset_d_wr_rdy", d_wr_rdy, 1);
        chk("areset_ret_data", ret_data_o, 0);
        tick;
        resetn = 1; ret_valid = 1; ret_last = 1;
        @(negedge clk);
        chk("post_reset_stray_d", d_ret_valid, 0);
        chk("post_reset_stray_i", i_ret_valid, 0);
        tick;
        ret_valid = 0; ret_last = 0; i_rd_req = 1; i_rd_addr = 32'h700;
        @(negedge clk);
        chk("post_reset_grant_cycle", rd_req, 0);
        tick;
        rd_rdy = 1;
        @(negedge clk);
        chk("post_reset_rd_addr", rd_addr, 32'h700);
        chk("post_reset_i_rd_rdy", i_rd_rdy, 1);
        tick;
        i_rd_req = 0; rd_rdy = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
